lfsr_checker: RTL

//  Receive-side companion to the 64-bit LFSR generator. Consumes the generator's serial

---
 rtl/lfsr_pkg.sv | 16 +
 rtl/lfsr_checker_if.sv | 21 ++
 rtl/lfsr_err_window.sv | 60 ++++++
 rtl/lfsr_checker.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and feedback helper for the 64-bit LFSR generator/checker pair.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    VERIFY  = 2'd1,
    LOCKED  = 2'd2
  } chk_state_t;

  localparam logic [63:0] TAPS64 = 64'hD800_0000_0000_0000;

  function automatic logic lfsr_fb(input logic [63:0] r, input logic [63:0] taps);
    return ^(r & taps);
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Serial stream input and status/counter outputs of the LFSR checker.
interface lfsr_checker_if;
  logic        bit_in;
  logic        bit_valid;
  logic        clear_counts;
  logic        locked;
  logic        bit_err;
  logic        lost_lock;
  logic [31:0] err_count;
  logic [31:0] bit_count;

  modport master (
    output bit_in, bit_valid, clear_counts,
    input  locked, bit_err, lost_lock, err_count, bit_count
  );

  modport slave (
    input  bit_in, bit_valid, clear_counts,
    output locked, bit_err, lost_lock, err_count, bit_count
  );
endinterface

// File: rtl/lfsr_err_window.sv
// Error-density monitor while locked: counts errors per window of accepted bits and
// strobes loss on the bit that brings the window's error tally to the threshold.
module lfsr_err_window #(
  parameter int WINDOW      = 256,
  parameter int LOSS_THRESH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic acc,
  input  logic err,
  output logic loss
);
  localparam int CW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(LOSS_THRESH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [EW-1:0] ERR_LAST = EW'(LOSS_THRESH - 1);
  localparam logic [EW-1:0] ERR_ZERO = EW'(0);
  localparam logic [EW-1:0] ERR_ONE  = EW'(1);

  logic [CW-1:0] cnt_r, cnt_s;
  logic [EW-1:0] errs_r, errs_s;

  assign loss = acc & err & (errs_r == ERR_LAST);

  // Window advance: loss or a fresh lock restarts; a full window without loss also restarts
  always_comb begin
    cnt_s  = cnt_r;
    errs_s = errs_r;
    if (clear || loss) begin
      cnt_s  = CNT_ZERO;
      errs_s = ERR_ZERO;
    end else if (acc) begin
      if (cnt_r == CNT_LAST) begin
        cnt_s  = CNT_ZERO;
        errs_s = ERR_ZERO;
      end else begin
        cnt_s  = cnt_r + CNT_ONE;
        errs_s = err ? (errs_r + ERR_ONE) : errs_r;
      end
    end else begin
      cnt_s  = cnt_r;
      errs_s = errs_r;
    end
  end

  // Window counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= CNT_ZERO;
      errs_r <= ERR_ZERO;
    end else begin
      cnt_r  <= cnt_s;
      errs_r <= errs_s;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising receive checker for the 64-bit LFSR stream: acquire, verify, then
// free-run on its own predictions while flagging and counting mismatched input bits.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int               WIDTH       = 64,
  parameter logic [WIDTH-1:0] TAPS        = TAPS64,
  parameter int               LOCK_MATCH  = 64,
  parameter int               WINDOW      = 256,
  parameter int               LOSS_THRESH = 16
) (
  input  logic          clk,
  input  logic          reset,
  lfsr_checker_if.slave bus
);
  localparam int FW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_MATCH + 1);
  localparam logic [FW-1:0]    FILL_LAST  = FW'(WIDTH - 1);
  localparam logic [FW-1:0]    FILL_ZERO  = FW'(0);
  localparam logic [FW-1:0]    FILL_ONE   = FW'(1);
  localparam logic [MW-1:0]    MATCH_LAST = MW'(LOCK_MATCH - 1);
  localparam logic [MW-1:0]    MATCH_ZERO = MW'(0);
  localparam logic [MW-1:0]    MATCH_ONE  = MW'(1);
  localparam logic [WIDTH-1:0] R_ZERO     = {WIDTH{1'b0}};
  localparam logic [31:0]      CNT_MAX    = 32'hFFFF_FFFF;

  chk_state_t       state_r, state_s;
  logic [WIDTH-1:0] r_r, r_s, shifted_s;
  logic [FW-1:0]    fill_r, fill_s;
  logic [MW-1:0]    match_r, match_s;
  logic             locked_r, bit_err_r, lost_lock_r, lost_lock_s;
  logic [31:0]      err_count_r, err_count_s, bit_count_r, bit_count_s;
  logic             pred_s, mismatch_s, win_acc_s, win_err_s, win_clear_s, loss_s;

  assign pred_s      = lfsr_fb(r_r, TAPS);
  assign mismatch_s  = bus.bit_in ^ pred_s;
  assign shifted_s   = {r_r[WIDTH-2:0], bus.bit_in};
  assign win_acc_s   = bus.bit_valid & (state_r == LOCKED);
  assign win_err_s   = win_acc_s & mismatch_s;
  assign win_clear_s = bus.bit_valid & (state_r == VERIFY) & ~mismatch_s & (match_r == MATCH_LAST);

  lfsr_err_window #(
    .WINDOW      (WINDOW),
    .LOSS_THRESH (LOSS_THRESH)
  ) u_err_window (
    .clk   (clk),
    .reset (reset),
    .clear (win_clear_s),
    .acc   (win_acc_s),
    .err   (win_err_s),
    .loss  (loss_s)
  );

  // Sequencing of fill, verification and free-running prediction
  always_comb begin
    state_s     = state_r;
    r_s         = r_r;
    fill_s      = fill_r;
    match_s     = match_r;
    lost_lock_s = 1'b0;
    if (bus.bit_valid) begin
      case (state_r)
        ACQUIRE: begin
          r_s = shifted_s;
          if (fill_r == FILL_LAST) begin
            fill_s = FILL_ZERO;
            // An all-zero register is the LFSR lock-up state; keep filling instead
            if (shifted_s == R_ZERO) begin
              state_s = ACQUIRE;
            end else begin
              state_s = VERIFY;
              match_s = MATCH_ZERO;
            end
          end else begin
            fill_s = fill_r + FILL_ONE;
          end
        end
        VERIFY: begin
          if (!mismatch_s) begin
            r_s = shifted_s;
            if (match_r == MATCH_LAST) begin
              state_s = LOCKED;
              match_s = MATCH_ZERO;
            end else begin
              match_s = match_r + MATCH_ONE;
            end
          end else begin
            state_s = ACQUIRE;
            fill_s  = FILL_ZERO;
            match_s = MATCH_ZERO;
          end
        end
        LOCKED: begin
          r_s = {r_r[WIDTH-2:0], pred_s};
          if (loss_s) begin
            state_s     = ACQUIRE;
            fill_s      = FILL_ZERO;
            lost_lock_s = 1'b1;
          end else begin
            state_s = LOCKED;
          end
        end
        default: begin
          state_s = ACQUIRE;
          fill_s  = FILL_ZERO;
          match_s = MATCH_ZERO;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Saturating counters; clear takes priority over an increment in the same cycle
  always_comb begin
    if (bus.clear_counts) begin
      err_count_s = 32'd0;
      bit_count_s = 32'd0;
    end else begin
      err_count_s = (win_err_s && (err_count_r != CNT_MAX)) ? (err_count_r + 32'd1) : err_count_r;
      bit_count_s = (win_acc_s && (bit_count_r != CNT_MAX)) ? (bit_count_r + 32'd1) : bit_count_r;
    end
  end

  // State, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ACQUIRE;
      r_r         <= R_ZERO;
      fill_r      <= FILL_ZERO;
      match_r     <= MATCH_ZERO;
      locked_r    <= 1'b0;
      bit_err_r   <= 1'b0;
      lost_lock_r <= 1'b0;
      err_count_r <= 32'd0;
      bit_count_r <= 32'd0;
    end else begin
      state_r     <= state_s;
      r_r         <= r_s;
      fill_r      <= fill_s;
      match_r     <= match_s;
      locked_r    <= (state_s == LOCKED);
      bit_err_r   <= win_err_s;
      lost_lock_r <= lost_lock_s;
      err_count_r <= err_count_s;
      bit_count_r <= bit_count_s;
    end
  end

  assign bus.locked    = locked_r;
  assign bus.bit_err   = bit_err_r;
  assign bus.lost_lock = lost_lock_r;
  assign bus.err_count = err_count_r;
  assign bus.bit_count = bit_count_r;

endmodule
